// File: rtl/approx_err_sweep.sv
`default_nettype none
// ============================================================================
//  Module   : approx_err_sweep
//  Purpose  : Exhaustive 8x8-bit operand sweep of an external approximate
//             adder, accumulating error count, signed sum, absolute sum,
//             squared sum and maximum absolute error.
//  Options  : ERR_SQ_EN - build the squared-error accumulator; when not
//             defined, sq_sum is tied to zero and no multiplier exists.
//  Revision : 1.0 - initial release
// ============================================================================
module approx_err_sweep (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic [7:0]         dut_a,
   output logic [7:0]         dut_b,
   input  logic [8:0]         dut_sum,
   output logic               busy,
   output logic               done,
   output logic [16:0]        err_count,
   output logic signed [25:0] err_sum,
   output logic [24:0]        abs_sum,
   output logic [33:0]        sq_sum,
   output logic [8:0]         max_abs_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [15:0] C_LAST_PAIR = 16'hFFFF;

   state_t              state_q, state_d;
   logic [15:0]         pair_q, pair_d;        // {a, b}; b is the inner index
   logic signed [10:0]  stage_q, stage_d;      // error of the previous pair
   logic                stage_vld_q, stage_vld_d;
   logic                done_q, done_d;
   logic [16:0]         err_count_q, err_count_d;
   logic signed [25:0]  err_sum_q, err_sum_d;
   logic [24:0]         abs_sum_q, abs_sum_d;
   logic [8:0]          max_abs_q, max_abs_d;

   logic                w_start_acc;
   logic [10:0]         w_pair_sum;
   logic signed [10:0]  w_err;
   logic signed [10:0]  w_neg;
   logic [9:0]          w_abs;

   // Error of the pair currently presented, and magnitude of the staged error
   always_comb begin
      w_pair_sum = {3'b000, pair_q[15:8]} + {3'b000, pair_q[7:0]};
      w_err      = $signed({2'b00, dut_sum}) - $signed(w_pair_sum);
      w_neg      = -stage_q;
      w_abs      = stage_q[10] ? w_neg[9:0] : stage_q[9:0];
   end

   // Next-state, operand sequencing, error staging and accumulation
   always_comb begin
      state_d     = state_q;
      pair_d      = pair_q;
      stage_d     = stage_q;
      stage_vld_d = 1'b0;
      err_count_d = err_count_q;
      err_sum_d   = err_sum_q;
      abs_sum_d   = abs_sum_q;
      max_abs_d   = max_abs_q;
      w_start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (abort)                     state_d = ST_IDLE;
            else if (pair_q == C_LAST_PAIR) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (abort) state_d = ST_IDLE;
            else       state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Operands advance only while the sweep continues; the last pair
      // stays on the bus through DRAIN and DONE.
      if (w_start_acc)
         pair_d = 16'd0;
      else if ((state_q == ST_RUN) && (state_d == ST_RUN))
         pair_d = pair_q + 16'd1;

      // An aborted cycle does not stage its pair
      if ((state_q == ST_RUN) && (state_d != ST_IDLE)) begin
         stage_d     = w_err;
         stage_vld_d = 1'b1;
      end

      if (w_start_acc) begin
         err_count_d = '0;
         err_sum_d   = '0;
         abs_sum_d   = '0;
         max_abs_d   = '0;
      end else if (stage_vld_q) begin
         if (stage_q != 11'sd0) err_count_d = err_count_q + 17'd1;
         err_sum_d = err_sum_q + {{15{stage_q[10]}}, stage_q};
         abs_sum_d = abs_sum_q + {15'd0, w_abs};
         if (w_abs > {1'b0, max_abs_q}) max_abs_d = w_abs[8:0];
      end

      // done rises one cycle after DONE is entered so the final
      // accumulation has settled; it drops on the edge a restart is taken.
      done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pair_q      <= '0;
         stage_q     <= '0;
         stage_vld_q <= 1'b0;
         done_q      <= 1'b0;
         err_count_q <= '0;
         err_sum_q   <= '0;
         abs_sum_q   <= '0;
         max_abs_q   <= '0;
      end else begin
         state_q     <= state_d;
         pair_q      <= pair_d;
         stage_q     <= stage_d;
         stage_vld_q <= stage_vld_d;
         done_q      <= done_d;
         err_count_q <= err_count_d;
         err_sum_q   <= err_sum_d;
         abs_sum_q   <= abs_sum_d;
         max_abs_q   <= max_abs_d;
      end
   end

`ifdef ERR_SQ_EN
   logic [33:0]        sq_sum_q, sq_sum_d;
   logic signed [21:0] w_sq;

   // Squared-error accumulation alongside the other totals
   always_comb begin
      w_sq     = stage_q * stage_q;
      sq_sum_d = sq_sum_q;
      if (w_start_acc)
         sq_sum_d = '0;
      else if (stage_vld_q)
         sq_sum_d = sq_sum_q + {12'd0, w_sq};
   end

   // Squared-error register
   always_ff @(posedge clk) begin
      if (rst) sq_sum_q <= '0;
      else     sq_sum_q <= sq_sum_d;
   end

   assign sq_sum = sq_sum_q;
`else
   assign sq_sum = '0;
`endif

   assign dut_a       = pair_q[15:8];
   assign dut_b       = pair_q[7:0];
   assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done        = done_q;
   assign err_count   = err_count_q;
   assign err_sum     = err_sum_q;
   assign abs_sum     = abs_sum_q;
   assign max_abs_err = max_abs_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_err_sweep.sv
`default_nettype none
// ============================================================================
//  Module   : tb_approx_err_sweep
//  Purpose  : Self-checking bench for approx_err_sweep with behavioural
//             approximate-adder models and a result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_approx_err_sweep;

   typedef struct {
      longint cnt;
      longint esum;
      longint asum;
      longint sq;
      longint mx;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst, start, abort;
   logic [7:0]         dut_a, dut_b;
   logic [8:0]         dut_sum;
   logic               busy, done;
   logic [16:0]        err_count;
   logic signed [25:0] err_sum;
   logic [24:0]        abs_sum;
   logic [33:0]        sq_sum;
   logic [8:0]         max_abs_err;

   int   mode;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];

   approx_err_sweep u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .dut_a       (dut_a),
      .dut_b       (dut_b),
      .dut_sum     (dut_sum),
      .busy        (busy),
      .done        (done),
      .err_count   (err_count),
      .err_sum     (err_sum),
      .abs_sum     (abs_sum),
      .sq_sum      (sq_sum),
      .max_abs_err (max_abs_err)
   );

   always #5 clk = ~clk;

   // Approximate adder models: 0 exact, 1 offset +1, 2 LSB forced to zero,
   // 3 mixed (one of the above per a-quadrant, top quadrant returns b only)
   function automatic logic [8:0] model_sum(input int m, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (m)
         0: return s;
         1: return s + 9'd1;
         2: return s & 9'h1FE;
         default: begin
            case (a[7:6])
               2'd0:    return s;
               2'd1:    return s + 9'd1;
               2'd2:    return s & 9'h1FE;
               default: return {1'b0, b};
            endcase
         end
      endcase
   endfunction

   always_comb dut_sum = model_sum(mode, dut_a, dut_b);

   // Expected totals over the first npairs pairs of the sweep order
   function automatic exp_t build_exp(input int m, input int npairs);
      exp_t e;
      int   err;
      logic [7:0] a, b;
      e = '{0, 0, 0, 0, 0};
      for (int k = 0; k < npairs; k++) begin
         a   = 8'(k >> 8);
         b   = 8'(k & 255);
         err = int'(model_sum(m, a, b)) - (int'(a) + int'(b));
         if (err != 0) e.cnt++;
         e.esum += err;
         e.asum += (err < 0) ? -err : err;
         e.sq   += err * err;
         if (((err < 0) ? -err : err) > e.mx) e.mx = (err < 0) ? -err : err;
      end
`ifndef ERR_SQ_EN
      e.sq = 0;
`endif
      return e;
   endfunction

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_results(input string pfx);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk({pfx, "_sb_empty"}, 1, 0);
         return;
      end
      e = exp_q.pop_front();
      chk({pfx, "_err_count"}, longint'(err_count), e.cnt);
      chk({pfx, "_err_sum"},   longint'(err_sum),   e.esum);
      chk({pfx, "_abs_sum"},   longint'(abs_sum),   e.asum);
      chk({pfx, "_sq_sum"},    longint'(sq_sum),    e.sq);
      chk({pfx, "_max_abs"},   longint'(max_abs_err), e.mx);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_busy"},      longint'(busy),        0);
      chk({pfx, "_done"},      longint'(done),        0);
      chk({pfx, "_dut_a"},     longint'(dut_a),       0);
      chk({pfx, "_dut_b"},     longint'(dut_b),       0);
      chk({pfx, "_err_count"}, longint'(err_count),   0);
      chk({pfx, "_err_sum"},   longint'(err_sum),     0);
      chk({pfx, "_abs_sum"},   longint'(abs_sum),     0);
      chk({pfx, "_sq_sum"},    longint'(sq_sum),      0);
      chk({pfx, "_max_abs"},   longint'(max_abs_err), 0);
   endtask

   initial begin
      int  cyc;
      bit  early;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      mode  = 1;
      tick();
      tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();

      // Reset in the middle of a sweep discards everything
      start = 1'b1; tick(); start = 1'b0;
      repeat (50) tick();
      chk("run_busy", longint'(busy), 1);
      chk("run_dut_b", longint'(dut_b), 50);
      rst = 1'b1; tick(); rst = 1'b0;
      chk_all_zero("rst_mid");

      // Abort after 1000 RUN cycles keeps the partial totals
      exp_q.push_back(build_exp(1, 999));
      start = 1'b1; tick(); start = 1'b0;
      repeat (999) tick();
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_busy",  longint'(busy),  0);
      chk("abort_done",  longint'(done),  0);
      chk("abort_dut_a", longint'(dut_a), 3);
      chk("abort_dut_b", longint'(dut_b), 231);
      chk_results("abort");
      repeat (5) tick();
      chk("idle_hold_dut_b", longint'(dut_b), 231);
      chk("idle_hold_cnt",   longint'(err_count), 999);

      // Full sweep: start wins over abort in IDLE, a start at RUN cycle 100 is ignored
      mode = 3;
      exp_q.push_back(build_exp(3, 65536));
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      chk("start_wins_busy", longint'(busy), 1);
      cyc   = 0;
      early = 1'b0;
      while (cyc < 65538) begin
         if (cyc == 99) start = 1'b1;
         tick();
         start = 1'b0;
         cyc++;
         if (cyc == 300) begin
            chk("seq_dut_a", longint'(dut_a), 1);
            chk("seq_dut_b", longint'(dut_b), 44);
         end
         if (cyc == 65536) chk("drain_busy", longint'(busy), 1);
         if (cyc == 65537) chk("pre_done",   longint'(done), 0);
         if (cyc < 65537 && done) early = 1'b1;
      end
      chk("done_early", longint'(early), 0);
      chk("done_at_T65538", longint'(done), 1);
      chk("done_busy", longint'(busy), 0);
      chk_results("sweep");

      // Results stay put in DONE
      repeat (10) tick();
      chk("done_hold", longint'(done), 1);
      exp_q.push_back(build_exp(3, 65536));
      chk_results("done_stable");

      // Restart from DONE clears everything on the accepting edge
      start = 1'b1; tick(); start = 1'b0;
      chk("restart_done",  longint'(done),        0);
      chk("restart_busy",  longint'(busy),        1);
      chk("restart_dut_a", longint'(dut_a),       0);
      chk("restart_cnt",   longint'(err_count),   0);
      chk("restart_max",   longint'(max_abs_err), 0);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("final_abort_busy", longint'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/approx_err_sweep.md
APPROX_ERR_SWEEP -- requirements
Module: approx_err_sweep

Interface
- REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
- REQ-002 Port: clk  input  1  rising-edge clock for all state.
- REQ-003 Port: rst  input  1  synchronous active-high reset.
- REQ-004 Port: start  input  1  pulse that requests an exhaustive sweep.
- REQ-005 Port: abort  input  1  terminates a sweep in progress.
- REQ-006 Port: dut_a  output  8  registered operand A driven to the approximate adder under test.
- REQ-007 Port: dut_b  output  8  registered operand B driven to the approximate adder under test.
- REQ-008 Port: dut_sum  input  9  combinational sum returned by the adder for the current dut_a/dut_b.
- REQ-009 Port: busy  output  1  high in states RUN and DRAIN.
- REQ-010 Port: done  output  1  high while in state DONE.
- REQ-011 Port: err_count  output  17  number of pairs with nonzero error.
- REQ-012 Port: err_sum  output  26  signed sum of errors.
- REQ-013 Port: abs_sum  output  25  sum of absolute errors.
- REQ-014 Port: sq_sum  output  34  sum of squared errors.
- REQ-015 Port: max_abs_err  output  9  largest absolute error seen.

Function
- REQ-016 The state machine SHALL have four states: IDLE, RUN, DRAIN and DONE.
- REQ-017 Transitions SHALL be:
  - IDLE/DONE --start--> RUN;
  - RUN --last pair (255,255) presented--> DRAIN;
  - DRAIN --> DONE;
  - RUN/DRAIN --abort--> IDLE.
- REQ-018 A start accepted in IDLE or DONE SHALL, on the same edge, clear all accumulators and max_abs_err and set dut_a = dut_b = 0.
- REQ-019 A start received in RUN or DRAIN SHALL be ignored.
- REQ-020 In RUN, dut_b SHALL increment every cycle; when dut_b wraps 255→0, dut_a SHALL increment, giving 65536 pairs with b as the inner index.
- REQ-021 Each RUN cycle SHALL register err = dut_sum − (dut_a + dut_b), computed as 11-bit signed, into a stage register.
- REQ-022 The accumulators SHALL add the stage register value one cycle later; DRAIN SHALL exist only to accumulate the final pair.
- REQ-023 The accumulator updates SHALL be:
  - err_count increments when err ≠ 0;
  - err_sum += err;
  - abs_sum += |err|;
  - sq_sum += err²;
  - max_abs_err = max(max_abs_err, |err|).
- REQ-024 Accumulators SHALL NOT saturate; the stated widths cover worst-case bounds (|err| ≤ 511).
- REQ-025 A start accepted at edge T SHALL produce done = 1 from edge T+65538; done SHALL hold until the next accepted start.
- REQ-026 Results SHALL remain stable while in DONE.
- REQ-027 An abort SHALL return the block to IDLE on the next edge with done = 0.
- REQ-028 After an abort, accumulators SHALL retain partial values until the next start.
- REQ-029 If start and abort are both asserted in IDLE or DONE, start SHALL win.
- REQ-030 If both are asserted in RUN or DRAIN, abort SHALL win.
- REQ-031 dut_a and dut_b SHALL hold their values in IDLE, DRAIN and DONE.

Reset
- REQ-032 When rst = 1 at a clock edge, the block SHALL enter IDLE.
- REQ-033 At that edge, busy, done, dut_a, dut_b, the stage register, all accumulators and max_abs_err SHALL become 0.
- REQ-034 Reset SHALL take priority over start and abort.
- REQ-035 Reset mid-sweep SHALL discard all partial results.

Configuration
- REQ-036 When macro ERR_SQ_EN is defined, the sq_sum accumulator and the squaring logic SHALL be built.
- REQ-037 When ERR_SQ_EN is not defined, sq_sum SHALL be constant 0 and no multiplier SHALL be inferred; all other behaviour SHALL be unchanged.

Verification
- REQ-038 Exact model (dut_sum = a+b), start at T -> done at T+65538; err_count = 0, err_sum = 0, abs_sum = 0, sq_sum = 0, max_abs_err = 0.
- REQ-039 Offset model (dut_sum = a+b+1) -> err_count = 65536, err_sum = 65536, abs_sum = 65536, sq_sum = 65536, max_abs_err = 1.
- REQ-040 LSB-forced-zero model (dut_sum = (a+b) & ~1) -> err_count = 32768, err_sum = −32768, abs_sum = 32768, sq_sum = 32768, max_abs_err = 1.
- REQ-041 Exact model with start repulsed at cycle 100 of RUN -> pair sequence unaffected; done at the original T+65538.
- REQ-042 Abort at cycle 1000 then restart with the offset model -> done = 0 after abort; fresh results equal to REQ-039.
- REQ-043 rst mid-RUN -> all outputs 0 and state IDLE on the next edge.
- REQ-044 Build without ERR_SQ_EN, offset model -> sq_sum = 0 and other results equal to REQ-039.
